// File: rtl/ppg_pkg.sv
// Shared constants and types for the pulse-ox FFT post-processing chain.
package ppg_pkg;

    localparam int unsigned MAG_W         = 24;
    localparam int unsigned HR_W          = 10;
    localparam int unsigned FFT_BINS      = 512;

    // Upstream sqrt pipeline emits one bogus zero at the head of every burst.
    localparam int unsigned SKIP_BEATS    = 1;

    // Heart-rate window and bin-to-BPM scaling (fs*60/NFFT = 256*60/1024).
    localparam int unsigned DEF_BPM_MUL   = 15;
    localparam int unsigned DEF_BPM_SHIFT = 0;
    localparam int unsigned DEF_MIN_BIN   = 3;
    localparam int unsigned DEF_MAX_BIN   = 14;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SKIP    = 3'd1,
        ST_COLLECT = 3'd2,
        ST_CALC    = 3'd3,
        ST_OUT     = 3'd4,
        ST_DRAIN   = 3'd5
    } picker_state_e;

endpackage

// File: rtl/fft_peak_picker_if.sv
// Magnitude stream in, AC/DC/heart-rate results out.
interface fft_peak_picker_if #(
    parameter int unsigned DATA_W = ppg_pkg::MAG_W,
    parameter int unsigned HR_W   = ppg_pkg::HR_W
);

    logic              mag_dv;
    logic [DATA_W-1:0] mag_data;
    logic [DATA_W-1:0] ac_comp;
    logic [DATA_W-1:0] dc_comp;
    logic [HR_W-1:0]   hr;
    logic              comp_dv;
    logic              frame_err;

    // Upstream / observer side.
    modport master (
        output mag_dv, mag_data,
        input  ac_comp, dc_comp, hr, comp_dv, frame_err
    );

    // Peak picker side.
    modport slave (
        input  mag_dv, mag_data,
        output ac_comp, dc_comp, hr, comp_dv, frame_err
    );

endinterface

// File: rtl/bin_to_bpm.sv
// Registered bin-index to BPM conversion: multiply, shift, saturate.
module bin_to_bpm #(
    parameter int unsigned IDX_W     = 9,
    parameter int unsigned BPM_MUL   = 15,
    parameter int unsigned BPM_SHIFT = 0,
    parameter int unsigned HR_W      = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [IDX_W-1:0] bin_idx,
    output logic [HR_W-1:0]  hr
);

    localparam int unsigned MUL_W = IDX_W + $clog2(BPM_MUL + 1);
    localparam int unsigned CMP_W = (MUL_W > HR_W) ? MUL_W : HR_W;

    logic [MUL_W-1:0] prod_c;
    logic [CMP_W-1:0] full_c;
    logic [HR_W-1:0]  sat_c;

    // Full-width product so large indices never wrap before saturation.
    assign prod_c = MUL_W'(bin_idx) * MUL_W'(BPM_MUL);
    assign full_c = CMP_W'(prod_c >> BPM_SHIFT);
    assign sat_c  = (full_c > CMP_W'({HR_W{1'b1}})) ? {HR_W{1'b1}} : HR_W'(full_c);

    // Capture the converted rate when the picker asks for it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hr <= '0;
        end else if (en) begin
            hr <= sat_c;
        end
    end

endmodule

// File: rtl/fft_peak_picker.sv
// Picks DC (bin 0) and the AC peak inside the heart-rate window from one
// FFT magnitude burst, and reports the peak as beats per minute.
module fft_peak_picker #(
    parameter int unsigned DATA_W    = ppg_pkg::MAG_W,
    parameter int unsigned SKIP      = ppg_pkg::SKIP_BEATS,
    parameter int unsigned FRAME_LEN = ppg_pkg::FFT_BINS,
    parameter int unsigned MIN_BIN   = ppg_pkg::DEF_MIN_BIN,
    parameter int unsigned MAX_BIN   = ppg_pkg::DEF_MAX_BIN,
    parameter int unsigned BPM_MUL   = ppg_pkg::DEF_BPM_MUL,
    parameter int unsigned BPM_SHIFT = ppg_pkg::DEF_BPM_SHIFT,
    parameter int unsigned HR_W      = ppg_pkg::HR_W
) (
    input  logic             clk,
    input  logic             reset_n,
    fft_peak_picker_if.slave bus
);

    import ppg_pkg::*;

    localparam int unsigned BIN_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned SKIP_W = $clog2(SKIP + 2);

    generate
        if (!(MIN_BIN > 0 && MIN_BIN <= MAX_BIN && MAX_BIN < FRAME_LEN)) begin : g_bad_params
            $error("fft_peak_picker: requires 0 < MIN_BIN <= MAX_BIN < FRAME_LEN");
        end
    endgenerate

    picker_state_e state;
    picker_state_e state_nxt;

    logic [BIN_W-1:0]  bin_idx;
    logic [BIN_W-1:0]  pk_idx;
    logic [SKIP_W-1:0] skip_cnt;
    logic [DATA_W-1:0] pk_mag;
    logic [DATA_W-1:0] dc_tmp;
    logic [DATA_W-1:0] ac_comp;
    logic [DATA_W-1:0] dc_comp;
    logic [HR_W-1:0]   hr;
    logic [HR_W-1:0]   bpm_hr;
    logic              comp_dv;
    logic              frame_err;

    logic              skip_done_c;
    logic              start_c;
    logic              skip_inc_c;
    logic              bin_c;
    logic              calc_c;
    logic              out_c;
    logic              err_c;
    logic [BIN_W-1:0]  cur_bin_c;

    assign skip_done_c = (skip_cnt == SKIP_W'(SKIP));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: frame walk, abort on a dropped valid, drain any overrun.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.mag_dv) begin
                    state_nxt = (SKIP > 0) ? ST_SKIP : ST_COLLECT;
                end
            end
            ST_SKIP: begin
                if (!bus.mag_dv) begin
                    state_nxt = ST_IDLE;
                end else if (skip_done_c) begin
                    state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (!bus.mag_dv) begin
                    state_nxt = ST_IDLE;
                end else if (bin_idx == BIN_W'(FRAME_LEN - 1)) begin
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC:  state_nxt = ST_OUT;
            ST_OUT:   state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!bus.mag_dv) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Per-state strobes. The beat that completes the skip count is bin 0,
    // so the bin index reads as 0 until COLLECT takes over.
    always_comb begin
        start_c    = 1'b0;
        skip_inc_c = 1'b0;
        bin_c      = 1'b0;
        calc_c     = 1'b0;
        out_c      = 1'b0;
        err_c      = 1'b0;
        cur_bin_c  = bin_idx;
        case (state)
            ST_IDLE: begin
                start_c   = bus.mag_dv;
                bin_c     = bus.mag_dv && (SKIP == 0);
                cur_bin_c = '0;
            end
            ST_SKIP: begin
                err_c      = !bus.mag_dv;
                skip_inc_c = bus.mag_dv && !skip_done_c;
                bin_c      = bus.mag_dv && skip_done_c;
                cur_bin_c  = '0;
            end
            ST_COLLECT: begin
                err_c = !bus.mag_dv;
                bin_c = bus.mag_dv;
            end
            ST_CALC: calc_c = 1'b1;
            ST_OUT:  out_c  = 1'b1;
            default: ;
        endcase
    end

    // Frame accumulators: DC latch, strict-greater peak search, bin counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_idx  <= '0;
            skip_cnt <= '0;
            pk_mag   <= '0;
            pk_idx   <= '0;
            dc_tmp   <= '0;
        end else begin
            if (start_c) begin
                skip_cnt <= SKIP_W'(1);
                bin_idx  <= '0;
                pk_mag   <= '0;
                pk_idx   <= BIN_W'(MIN_BIN);
            end else if (skip_inc_c) begin
                skip_cnt <= skip_cnt + SKIP_W'(1);
            end
            if (bin_c) begin
                bin_idx <= cur_bin_c + BIN_W'(1);
                if (cur_bin_c == '0) begin
                    dc_tmp <= bus.mag_data;
                end
                if (cur_bin_c >= BIN_W'(MIN_BIN) && cur_bin_c <= BIN_W'(MAX_BIN) &&
                    bus.mag_data > pk_mag) begin
                    pk_mag <= bus.mag_data;
                    pk_idx <= cur_bin_c;
                end
            end
        end
    end

    bin_to_bpm #(
        .IDX_W     (BIN_W),
        .BPM_MUL   (BPM_MUL),
        .BPM_SHIFT (BPM_SHIFT),
        .HR_W      (HR_W)
    ) u_bin_to_bpm (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (calc_c),
        .bin_idx (pk_idx),
        .hr      (bpm_hr)
    );

    // Result registers: load on OUT, hold otherwise; pulses last one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ac_comp   <= '0;
            dc_comp   <= '0;
            hr        <= '0;
            comp_dv   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            comp_dv   <= out_c;
            frame_err <= err_c;
            if (out_c) begin
                ac_comp <= pk_mag;
                dc_comp <= dc_tmp;
                hr      <= bpm_hr;
            end
        end
    end

    assign bus.ac_comp   = ac_comp;
    assign bus.dc_comp   = dc_comp;
    assign bus.hr        = hr;
    assign bus.comp_dv   = comp_dv;
    assign bus.frame_err = frame_err;

endmodule

// File: tb/tb_fft_peak_picker.sv
// Bench for fft_peak_picker: two instances (default scaling and BPM_MUL=100)
// share one magnitude stream; a frame-level model predicts every result.
module tb_fft_peak_picker;

    localparam int unsigned DATA_W    = 24;
    localparam int unsigned HR_W      = 10;
    localparam int unsigned SKIP      = 1;
    localparam int unsigned FRAME_LEN = 512;
    localparam int unsigned MIN_BIN   = 3;
    localparam int unsigned MAX_BIN   = 14;
    localparam int unsigned BPM_MUL   = 15;
    localparam int unsigned BPM_MUL_S = 100;
    localparam int unsigned BPM_SHIFT = 0;
    localparam int unsigned HR_MAX    = (1 << HR_W) - 1;
    localparam int unsigned FULL_LEN  = SKIP + FRAME_LEN;

    typedef struct {
        longint unsigned cyc;
        bit              is_err;
        int unsigned     ac;
        int unsigned     dc;
        int unsigned     hr;
        int unsigned     hrs;
    } ev_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              mag_dv = 1'b0;
    logic [DATA_W-1:0] mag_data = '0;

    longint unsigned edge_n = 0;
    ev_t             ev_q[$];
    int unsigned     ev_rd = 0;
    int unsigned     beats[0:599];

    int unsigned     lit_ac = 0;
    int unsigned     lit_dc = 0;
    int unsigned     lit_hr = 0;
    int unsigned     lit_hrs = 0;
    int unsigned     lit_seq = 0;
    int unsigned     lit_done = 0;
    bit              tb_done = 1'b0;

    int unsigned     checks = 0;
    int unsigned     errors = 0;

    int unsigned     e_ac = 0;
    int unsigned     e_dc = 0;
    int unsigned     e_hr = 0;
    int unsigned     e_hrs = 0;
    bit              e_dv = 1'b0;
    bit              e_err = 1'b0;

    fft_peak_picker_if #(.DATA_W(DATA_W), .HR_W(HR_W)) bus ();
    fft_peak_picker_if #(.DATA_W(DATA_W), .HR_W(HR_W)) bus_s ();

    assign bus.mag_dv     = mag_dv;
    assign bus.mag_data   = mag_data;
    assign bus_s.mag_dv   = mag_dv;
    assign bus_s.mag_data = mag_data;

    fft_peak_picker #(
        .DATA_W(DATA_W), .SKIP(SKIP), .FRAME_LEN(FRAME_LEN), .MIN_BIN(MIN_BIN),
        .MAX_BIN(MAX_BIN), .BPM_MUL(BPM_MUL), .BPM_SHIFT(BPM_SHIFT), .HR_W(HR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    fft_peak_picker #(
        .DATA_W(DATA_W), .SKIP(SKIP), .FRAME_LEN(FRAME_LEN), .MIN_BIN(MIN_BIN),
        .MAX_BIN(MAX_BIN), .BPM_MUL(BPM_MUL_S), .BPM_SHIFT(BPM_SHIFT), .HR_W(HR_W)
    ) dut_sat (
        .clk(clk), .reset_n(reset_n), .bus(bus_s)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge n, edge_n == n.
    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
        end
    end

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned to_bpm(input int unsigned idx, input int unsigned mul);
        int unsigned v;
        v = (idx * mul) >> BPM_SHIFT;
        return (v > HR_MAX) ? HR_MAX : v;
    endfunction

    // Frame-level model: DC is the first beat after the skip; AC is the first
    // maximum (strictly greater wins) over the window, zero-init at MIN_BIN.
    task automatic model_frame(output int unsigned ac, output int unsigned dc,
                               output int unsigned hr, output int unsigned hrs);
        int unsigned idx;
        dc  = beats[SKIP];
        ac  = 0;
        idx = MIN_BIN;
        for (int b = MIN_BIN; b <= MAX_BIN; b++) begin
            if (beats[SKIP + b] > ac) begin
                ac  = beats[SKIP + b];
                idx = b;
            end
        end
        hr  = to_bpm(idx, BPM_MUL);
        hrs = to_bpm(idx, BPM_MUL_S);
    endtask

    task automatic fill(input int unsigned v);
        for (int i = 0; i < 600; i++) beats[i] = v;
    endtask

    task automatic rand_fill();
        int unsigned mode;
        mode = $urandom_range(0, 2);
        for (int i = 0; i < 600; i++) begin
            case (mode)
                0:       beats[i] = $urandom_range(0, 15);
                1:       beats[i] = $urandom & 32'h00FF_FFFF;
                default: beats[i] = (i >= SKIP + MIN_BIN && i <= SKIP + MAX_BIN) ? 0
                                    : ($urandom & 32'h00FF_FFFF);
            endcase
        end
    endtask

    // Drive one burst of len beats, then gap idle cycles; queue the expected event.
    task automatic run_burst(input int unsigned len, input int unsigned gap);
        ev_t ev;
        int unsigned ac, dc, hr, hrs;
        for (int i = 0; i < int'(len); i++) begin
            step();
            mag_dv   = 1'b1;
            mag_data = DATA_W'(beats[i]);
            if (i == 0) begin
                if (len >= FULL_LEN) begin
                    model_frame(ac, dc, hr, hrs);
                    ev = '{edge_n + FULL_LEN + 2, 1'b0, ac, dc, hr, hrs};
                end else begin
                    ev = '{edge_n + len + 1, 1'b1, 0, 0, 0, 0};
                end
                ev_q.push_back(ev);
            end
        end
        step();
        mag_dv   = 1'b0;
        mag_data = '0;
        repeat (gap) step();
    endtask

    task automatic lit(input int unsigned ac, input int unsigned dc,
                       input int unsigned hr, input int unsigned hrs);
        lit_ac  = ac;
        lit_dc  = dc;
        lit_hr  = hr;
        lit_hrs = hrs;
        lit_seq++;
        step();
    endtask

    // Compare process: every cycle, both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            e_dv  = 1'b0;
            e_err = 1'b0;
            if (!reset_n) begin
                ev_rd = ev_q.size();
                e_ac  = 0;
                e_dc  = 0;
                e_hr  = 0;
                e_hrs = 0;
            end else if (ev_rd < ev_q.size() && ev_q[ev_rd].cyc == edge_n) begin
                if (ev_q[ev_rd].is_err) begin
                    e_err = 1'b1;
                end else begin
                    e_dv  = 1'b1;
                    e_ac  = ev_q[ev_rd].ac;
                    e_dc  = ev_q[ev_rd].dc;
                    e_hr  = ev_q[ev_rd].hr;
                    e_hrs = ev_q[ev_rd].hrs;
                end
                ev_rd++;
            end
            chk("comp_dv",       bus.comp_dv,     e_dv);
            chk("frame_err",     bus.frame_err,   e_err);
            chk("ac_comp",       bus.ac_comp,     e_ac);
            chk("dc_comp",       bus.dc_comp,     e_dc);
            chk("hr",            bus.hr,          e_hr);
            chk("sat_comp_dv",   bus_s.comp_dv,   e_dv);
            chk("sat_frame_err", bus_s.frame_err, e_err);
            chk("sat_ac_comp",   bus_s.ac_comp,   e_ac);
            chk("sat_dc_comp",   bus_s.dc_comp,   e_dc);
            chk("sat_hr",        bus_s.hr,        e_hrs);
            if (lit_seq != lit_done) begin
                lit_done = lit_seq;
                chk("lit_ac",     bus.ac_comp, lit_ac);
                chk("lit_dc",     bus.dc_comp, lit_dc);
                chk("lit_hr",     bus.hr,      lit_hr);
                chk("lit_sat_hr", bus_s.hr,    lit_hrs);
            end
            if (tb_done) begin
                chk("pending_events", ev_q.size() - ev_rd, 0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    // Stimulus.
    initial begin
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        lit(0, 0, 0, 0);

        // Basic frame.
        fill(10);
        beats[0]        = 0;
        beats[SKIP + 0] = 1000;
        beats[SKIP + 5] = 800;
        run_burst(FULL_LEN, 4);
        lit(800, 1000, 75, 500);

        // Ties, window edges, out-of-window peaks.
        fill(10);
        beats[0]         = 0;
        beats[SKIP + 3]  = 500;
        beats[SKIP + 9]  = 500;
        beats[SKIP + 14] = 499;
        beats[SKIP + 2]  = 900;
        beats[SKIP + 15] = 900;
        run_burst(FULL_LEN, 4);
        lit(500, 10, 45, 300);

        // Abort after bin 100: previous results held.
        rand_fill();
        run_burst(SKIP + 101, 4);
        lit(500, 10, 45, 300);

        // Full valid frame after the abort.
        rand_fill();
        run_burst(FULL_LEN, 4);

        // Overlong burst: trailing beats must be ignored.
        fill(20);
        beats[SKIP]     = 3;
        beats[SKIP + 7] = 2000;
        for (int i = FULL_LEN; i < 520; i++) beats[i] = 32'h00FF_FFFF;
        run_burst(520, 4);
        lit(2000, 3, 105, 700);

        // Peak at the top of the window: 1400 saturates on the x100 instance.
        fill(5);
        beats[SKIP]      = 7;
        beats[SKIP + 14] = 60000;
        run_burst(FULL_LEN, 4);
        lit(60000, 7, 210, 1023);

        // Reset asserted at bin 300.
        rand_fill();
        for (int i = 0; i <= int'(SKIP + 300); i++) begin
            step();
            mag_dv   = 1'b1;
            mag_data = DATA_W'(beats[i]);
        end
        step();
        reset_n  = 1'b0;
        mag_dv   = 1'b0;
        mag_data = '0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
        lit(0, 0, 0, 0);
        rand_fill();
        run_burst(FULL_LEN, 4);

        // Randomized bursts: full, overlong and aborted.
        for (int k = 0; k < 8; k++) begin
            int unsigned sel;
            int unsigned len;
            rand_fill();
            sel = $urandom_range(0, 9);
            if (sel < 5)      len = FULL_LEN;
            else if (sel < 7) len = FULL_LEN + $urandom_range(1, 8);
            else              len = $urandom_range(1, FULL_LEN - 1);
            run_burst(len, $urandom_range(4, 8));
        end

        tb_done = 1'b1;
        repeat (5) step();
        $display("FAIL watchdog: compare process did not finish");
        $fatal(1);
    end

endmodule
